cpu_sm_outreg: RTL and testbench
================================

# cpu_sm_outreg

Registered output stage of the CPU bus-master state machine. Captures the next-state output decode (the `*_d` terms) on each clock edge and drives the glitch-free 68030-side bus strobes, bus-arbitration lines and FIFO/bridge controls. It converts level FIFO-count requests into single-cycle strobes. An optional watchdog aborts a bus cycle that never terminates.

## Interface
Parameters:
- WDOG_CYCLES, 255, clocks PAS_ may stay asserted before watchdog abort (1..2^WDOG_W-1)
- WDOG_W, 8, watchdog counter width

Ports:
- CLK  in  1  state-machine clock; all logic on rising edge
- RST  in  1  synchronous reset, active-high
- SM_D  in  18  decode outputs, active-high except where named n*: [0] nINCNI_d, [1] nBREQ_d, [2] SIZE1_d, [3] PAS_d, [4] PDS_d, [5] F2CPUL_d, [6] F2CPUH_d, [7] BRIDGEOUT_d, [8] PLLW_d, [9] PLHW_d, [10] INCFIFO_d, [11] DECFIFO_d, [12] INCNO_d, [13] nSTOPFLUSH_d, [14] DIEH_d, [15] DIEL_d, [16] nBRIDGEIN_d, [17] BGACK_d
- PAS_  out  1  address strobe, active-low
- PDS_  out  1  data strobe, active-low
- SIZE1  out  1  bus SIZ1
- BREQ_  out  1  bus request, active-low
- BGACK_  out  1  bus grant acknowledge, active-low
- BUSOE  out  1  drive enable for address/strobe/size pads
- F2CPU  out  2  {H,L} FIFO-to-CPU data word enables
- PLW  out  2  {PLHW,PLLW} packing-latch word strobes
- DIE  out  2  {DIEH,DIEL} data-in latch enables
- BRIDGEOUT  out  1  byte bridge, FIFO to bus
- BRIDGEIN  out  1  byte bridge, bus to FIFO
- INCFIFO  out  1  one-cycle FIFO count increment
- DECFIFO  out  1  one-cycle FIFO count decrement
- INCNI  out  1  one-cycle input pointer increment
- INCNO  out  1  one-cycle output pointer increment
- STOPFLUSH  out  1  flush stop request, active-high
- WDOG_TRIP  out  1  watchdog abort flag

## Operation
- Level register: each SM_D bit captured every edge into q[17:0]; all level outputs come from q or flops, never from SM_D directly.
- Inversions: BREQ_ = q[1] (input is already the active-low form); nINCNI/nSTOPFLUSH/nBRIDGEIN inverted to active-high INCNI request, STOPFLUSH, BRIDGEIN.
- PAS_ = ~(q[3] & ~abort); PDS_ = ~(q[4] & q[3] & ~abort). PDS_ is never low while PAS_ is high.
- BGACK_ = ~q[17]; BUSOE = q[17]. SIZE1 = q[2] & q[17]; SIZE1 is 0 while the bus is not owned.
- Pulse generator for bits 0 (inverted), 10, 11, 12: pulse = req & ~prev, where prev = last-cycle req. A level held N cycles gives exactly one pulse.
- INCFIFO and DECFIFO rising in the same cycle: both pulses suppressed (net zero).
- Watchdog: see Configuration. abort is set on trip and held until SM_D[3] is sampled 0, then it clears. WDOG_TRIP = abort.

## Timing
- Latency: every output reflects SM_D sampled at edge k, valid after edge k. Latency is one cycle.
- Pulses are exactly one cycle wide. The same request must drop for ≥1 cycle before it can re-pulse.
- Reset (RST=1 at an edge): q cleared so that PAS_=PDS_=BREQ_=BGACK_=1, BUSOE=0, SIZE1=0, F2CPU=PLW=DIE=0, BRIDGEOUT=BRIDGEIN=0, INCFIFO=DECFIFO=INCNI=INCNO=0, STOPFLUSH=0, WDOG_TRIP=0, counter=0. prev registers are cleared to inactive, so a request already high after reset pulses once.
- Reset mid-cycle has priority over all: strobes deassert on that edge with no pulse emitted.

## Configuration
- CPU_SM_WATCHDOG_EN defined:
  - WDOG_W-bit counter increments each cycle that q[3]=1 and abort=0.
  - Counter clears when q[3]=0.
  - When the count reaches WDOG_CYCLES, abort is set on the next edge: PAS_/PDS_ forced high and WDOG_TRIP=1.
  - Counter saturates while aborted.
- CPU_SM_WATCHDOG_EN undefined: no counter, abort constant 0, WDOG_TRIP tied 0.

## Test plan
- Reset with SM_D=18'h3FFFF, then release RST: every output holds its reset value during reset. After release: PAS_=0, BGACK_=0, BUSOE=1, and one-cycle INCFIFO/DECFIFO suppressed (coincident); INCNO=1 for one cycle; INCNI=0.
- SM_D[10] high for 5 cycles, low 1, high 2: INCFIFO pulses exactly twice, each one cycle wide, each one cycle after the rise.
- SM_D[4]=1 with SM_D[3]=0: PDS_ stays 1. Then set SM_D[3]=1: PAS_ and PDS_ both go 0 on the same edge.
- SM_D[2]=1 with SM_D[17]=0: SIZE1=0. Set SM_D[17]=1: SIZE1=1 and BUSOE=1 one edge later.
- Watchdog enabled, WDOG_CYCLES=4, hold SM_D[3]=SM_D[4]=1: PAS_ low 5 cycles, then PAS_=PDS_=1 and WDOG_TRIP=1. Drop SM_D[3] for one cycle: WDOG_TRIP clears. Macro undefined: PAS_ stays low indefinitely.
- Assert RST while PAS_=0 and SM_D[11] rising: next edge PAS_=1, DECFIFO=0.

Source files
------------

// File: rtl/cpu_sm_outreg_if.sv
// Bus bundle between the CPU state-machine decode (master) and its registered
// output stage (slave): the 18-bit decode word in, bus strobes and controls out.
interface cpu_sm_outreg_if;
    localparam int unsigned SmW = 18;

    logic [SmW-1:0] SM_D;
    logic           PAS_;
    logic           PDS_;
    logic           SIZE1;
    logic           BREQ_;
    logic           BGACK_;
    logic           BUSOE;
    logic [1:0]     F2CPU;
    logic [1:0]     PLW;
    logic [1:0]     DIE;
    logic           BRIDGEOUT;
    logic           BRIDGEIN;
    logic           INCFIFO;
    logic           DECFIFO;
    logic           INCNI;
    logic           INCNO;
    logic           STOPFLUSH;
    logic           WDOG_TRIP;

    modport master (
        output SM_D,
        input  PAS_, PDS_, SIZE1, BREQ_, BGACK_, BUSOE, F2CPU, PLW, DIE,
               BRIDGEOUT, BRIDGEIN, INCFIFO, DECFIFO, INCNI, INCNO,
               STOPFLUSH, WDOG_TRIP
    );

    modport slave (
        input  SM_D,
        output PAS_, PDS_, SIZE1, BREQ_, BGACK_, BUSOE, F2CPU, PLW, DIE,
               BRIDGEOUT, BRIDGEIN, INCFIFO, DECFIFO, INCNI, INCNO,
               STOPFLUSH, WDOG_TRIP
    );
endinterface

// File: rtl/cpu_sm_outreg.sv
// Registered output stage of the CPU bus-master state machine: level capture,
// single-cycle FIFO/pointer strobes, optional bus-cycle watchdog (CPU_SM_WATCHDOG_EN).
module cpu_sm_outreg #(
    parameter int unsigned WDOG_CYCLES = 255,
    parameter int unsigned WDOG_W      = 8
) (
    input  logic            CLK,
    input  logic            RST,
    cpu_sm_outreg_if.slave  bus
);
    localparam int unsigned SmW = 18;
    // Idle decode word: active-low inputs (nINCNI, nBREQ, nSTOPFLUSH, nBRIDGEIN) held inactive.
    localparam logic [SmW-1:0] QReset = 18'h12003;

    logic [SmW-1:0] q;
    logic           abort;
    logic           inc_fifo;
    logic           dec_fifo;
    logic           inc_ni;
    logic           inc_no;

    logic           inc_rise;
    logic           dec_rise;
    logic           ni_rise;
    logic           no_rise;

    // Rising-edge detect of each count request against its last-cycle level held in q.
    always_comb begin
        inc_rise = bus.SM_D[10] & ~q[10];
        dec_rise = bus.SM_D[11] & ~q[11];
        ni_rise  = ~bus.SM_D[0] & q[0];
        no_rise  = bus.SM_D[12] & ~q[12];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q        <= QReset;
            inc_fifo <= 1'b0;
            dec_fifo <= 1'b0;
            inc_ni   <= 1'b0;
            inc_no   <= 1'b0;
        end else begin
            q        <= bus.SM_D;
            // Coincident increment and decrement cancel out.
            inc_fifo <= inc_rise & ~dec_rise;
            dec_fifo <= dec_rise & ~inc_rise;
            inc_ni   <= ni_rise;
            inc_no   <= no_rise;
        end
    end

`ifdef CPU_SM_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    // Count strobe-asserted cycles; abort holds until the address strobe request drops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_cnt <= '0;
            abort    <= 1'b0;
        end else begin
            if (!q[3]) begin
                wdog_cnt <= '0;
            end else if (!abort && (wdog_cnt != WDOG_W'(WDOG_CYCLES))) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end

            if (abort) begin
                abort <= bus.SM_D[3];
            end else if (bus.SM_D[3] && q[3] && (wdog_cnt == WDOG_W'(WDOG_CYCLES))) begin
                abort <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog;

    assign abort       = 1'b0;
    assign unused_wdog = ^WDOG_W'(WDOG_CYCLES);
`endif

    // Output decode straight from flops; PDS_ is qualified by PAS_ so it never leads it.
    assign bus.PAS_      = ~(q[3] & ~abort);
    assign bus.PDS_      = ~(q[4] & q[3] & ~abort);
    assign bus.SIZE1     = q[2] & q[17];
    assign bus.BREQ_     = q[1];
    assign bus.BGACK_    = ~q[17];
    assign bus.BUSOE     = q[17];
    assign bus.F2CPU     = {q[6], q[5]};
    assign bus.PLW       = {q[9], q[8]};
    assign bus.DIE       = {q[14], q[15]};
    assign bus.BRIDGEOUT = q[7];
    assign bus.BRIDGEIN  = ~q[16];
    assign bus.STOPFLUSH = ~q[13];
    assign bus.INCFIFO   = inc_fifo;
    assign bus.DECFIFO   = dec_fifo;
    assign bus.INCNI     = inc_ni;
    assign bus.INCNO     = inc_no;
    assign bus.WDOG_TRIP = abort;
endmodule

// File: tb/tb_cpu_sm_outreg.sv
// Self-checking bench for cpu_sm_outreg: directed vector table, watchdog
// sequence, and randomized decode words against a behavioural model.
module tb_cpu_sm_outreg;
    localparam int unsigned WdogCycles = 4;
`ifdef CPU_SM_WATCHDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [17:0] sm;
        logic [7:0]  exp;   // {PAS_,PDS_,SIZE1,BUSOE,INCFIFO,DECFIFO,INCNO,INCNI}
    } vec_t;

    logic CLK;
    logic RST;
    cpu_sm_outreg_if bus_if();

    cpu_sm_outreg #(.WDOG_CYCLES(WdogCycles), .WDOG_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] dut_vec;
    logic [7:0]  dut8;
    assign dut_vec = {bus_if.PAS_, bus_if.PDS_, bus_if.SIZE1, bus_if.BREQ_, bus_if.BGACK_,
                      bus_if.BUSOE, bus_if.F2CPU, bus_if.PLW, bus_if.DIE, bus_if.BRIDGEOUT,
                      bus_if.BRIDGEIN, bus_if.INCFIFO, bus_if.DECFIFO, bus_if.INCNI,
                      bus_if.INCNO, bus_if.STOPFLUSH, bus_if.WDOG_TRIP};
    assign dut8 = {bus_if.PAS_, bus_if.PDS_, bus_if.SIZE1, bus_if.BUSOE,
                   bus_if.INCFIFO, bus_if.DECFIFO, bus_if.INCNO, bus_if.INCNI};

    // Model state: last request levels {inc, dec, ni, no} and length of the current PAS request run.
    logic [3:0]  m_prev;
    int          m_run;
    logic [19:0] m_exp;

    task automatic model_update(input logic r, input logic [17:0] s);
        logic [3:0] req;
        logic [3:0] rise;
        logic       ab;
        if (r) begin
            m_prev = 4'b0000;
            m_run  = 0;
            m_exp  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0, 8'b0};
        end else begin
            req  = {s[10], s[11], ~s[0], s[12]};
            rise = req & ~m_prev;
            m_run = s[3] ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            // Strobe driven for WDOG_CYCLES+1 cycles, aborted on the next one.
            ab = WdEn && (m_run >= int'(WdogCycles) + 2);
            m_exp = {~(s[3] & ~ab), ~(s[4] & s[3] & ~ab), s[2] & s[17], s[1], ~s[17], s[17],
                     {s[6], s[5]}, {s[9], s[8]}, {s[14], s[15]}, s[7], ~s[16],
                     rise[3] & ~rise[2], rise[2] & ~rise[3], rise[1], rise[0], ~s[13], ab};
            m_prev = req;
        end
    endtask

    task automatic step(input logic r, input logic [17:0] s);
        @(negedge CLK);
        RST = r;
        bus_if.SM_D = s;
        @(posedge CLK);
        model_update(r, s);
        #1;
    endtask

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t tbl[$];

    initial begin
        RST = 1'b1;
        bus_if.SM_D = '0;
        m_prev = '0;
        m_run  = 0;
        m_exp  = '0;

        tbl.push_back('{1'b1, 18'h3FFFF, 8'hC0});
        tbl.push_back('{1'b1, 18'h3FFFF, 8'hC0});
        tbl.push_back('{1'b0, 18'h3FFFF, 8'h32});
        tbl.push_back('{1'b0, 18'h3FFFF, 8'h30});
        tbl.push_back('{1'b0, 18'h12003, 8'hC0});
        tbl.push_back('{1'b0, 18'h12403, 8'hC8});
        tbl.push_back('{1'b0, 18'h12403, 8'hC0});
        tbl.push_back('{1'b0, 18'h12403, 8'hC0});
        tbl.push_back('{1'b0, 18'h12403, 8'hC0});
        tbl.push_back('{1'b0, 18'h12403, 8'hC0});
        tbl.push_back('{1'b0, 18'h12003, 8'hC0});
        tbl.push_back('{1'b0, 18'h12403, 8'hC8});
        tbl.push_back('{1'b0, 18'h12403, 8'hC0});
        tbl.push_back('{1'b0, 18'h12003, 8'hC0});
        tbl.push_back('{1'b0, 18'h12803, 8'hC4});
        tbl.push_back('{1'b0, 18'h12C03, 8'hC8});
        tbl.push_back('{1'b0, 18'h12003, 8'hC0});
        tbl.push_back('{1'b0, 18'h12002, 8'hC1});
        tbl.push_back('{1'b0, 18'h12002, 8'hC0});
        tbl.push_back('{1'b0, 18'h12013, 8'hC0});
        tbl.push_back('{1'b0, 18'h1201B, 8'h00});
        tbl.push_back('{1'b0, 18'h12007, 8'hC0});
        tbl.push_back('{1'b0, 18'h32007, 8'hF0});
        tbl.push_back('{1'b0, 18'h1200B, 8'h40});
        tbl.push_back('{1'b1, 18'h1280B, 8'hC0});
        tbl.push_back('{1'b0, 18'h1280B, 8'h44});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sm);
            chk($sformatf("vec%0d", i), 20'(dut8), 20'(tbl[i].exp));
            if (tbl[i].rst)
                chk($sformatf("vec%0d_reset_all", i), dut_vec, 20'hD8000);
        end

        // Long bus cycle: aborted after WDOG_CYCLES+1 strobe cycles only when the watchdog is built in.
        step(1'b0, 18'h12003);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 18'h1201B);
            chk($sformatf("wd_low%0d", i), {17'b0, bus_if.PAS_, bus_if.PDS_, bus_if.WDOG_TRIP}, 20'b000);
        end
        if (WdEn) begin
            step(1'b0, 18'h1201B);
            chk("wd_trip", {17'b0, bus_if.PAS_, bus_if.PDS_, bus_if.WDOG_TRIP}, 20'b111);
            step(1'b0, 18'h1201B);
            chk("wd_hold", {17'b0, bus_if.PAS_, bus_if.PDS_, bus_if.WDOG_TRIP}, 20'b111);
            step(1'b0, 18'h12013);
            chk("wd_clear", {17'b0, bus_if.PAS_, bus_if.PDS_, bus_if.WDOG_TRIP}, 20'b110);
            step(1'b0, 18'h1201B);
            chk("wd_rearm", {17'b0, bus_if.PAS_, bus_if.PDS_, bus_if.WDOG_TRIP}, 20'b000);
        end else begin
            for (int i = 0; i < 20; i++) begin
                step(1'b0, 18'h1201B);
                chk($sformatf("nowd_low%0d", i), {17'b0, bus_if.PAS_, bus_if.PDS_, bus_if.WDOG_TRIP}, 20'b000);
            end
        end

        // Random decode words, PAS request biased high so watchdog runs occur.
        for (int i = 0; i < 600; i++) begin
            logic [17:0] s;
            logic        r;
            s = 18'($urandom);
            s[3] = (($urandom % 8) != 0);
            r = (($urandom % 40) == 0);
            step(r, s);
            chk($sformatf("rand%0d", i), dut_vec, m_exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
